rps_match_ctrl: RTL

Match controller for the rock-paper-scissors lab datapath. Conditions the raw active-low play button, latches both players' 2-bit plays on each accepted press, and holds them stable for a reveal window. It resolves each round, keeps per-player scores, and ends the match when either player reaches a target win count. It sits between the board switches/button and the combinational win/lose display logic, which it drives with the latched plays.

---
 rtl/rps_pkg.sv | 36 +++
 rtl/rps_match_ctrl_if.sv | 27 ++
 rtl/rps_button_cond.sv | 61 ++++++
 rtl/rps_match_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared encodings, FSM state type and round-resolution helper for the rock-paper-scissors match controller.
package rps_pkg;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        ROCK     = 2'b01,
        PAPER    = 2'b10,
        SCISSORS = 2'b11
    } play_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_TIE  = 2'b11
    } result_t;

    typedef enum logic [2:0] {
        WAIT_RELEASE,
        WAIT_PRESS,
        REVEAL,
        SCORE,
        MATCH_OVER
    } state_t;

    function automatic result_t rps_winner(input logic [1:0] p1, input logic [1:0] p2);
        if (p1 == p2)
            return RES_TIE;
        if ((p1 == ROCK     && p2 == SCISSORS) ||
            (p1 == SCISSORS && p2 == PAPER)    ||
            (p1 == PAPER    && p2 == ROCK))
            return RES_P1;
        return RES_P2;
    endfunction

endpackage

// File: rtl/rps_match_ctrl_if.sv
// Board-side bundle: raw plays and button in, latched plays, result and match status out.
interface rps_match_ctrl_if;
    logic [1:0] p1Play;
    logic [1:0] p2Play;
    logic       playButton;
    logic [1:0] p1Latch;
    logic [1:0] p2Latch;
    logic [1:0] result;
    logic       roundValid;
    logic [3:0] p1Score;
    logic [3:0] p2Score;
    logic [7:0] roundCount;
    logic       matchOver;
    logic       badPlay;

    modport master (
        output p1Play, p2Play, playButton,
        input  p1Latch, p2Latch, result, roundValid, p1Score, p2Score,
               roundCount, matchOver, badPlay
    );

    modport slave (
        input  p1Play, p2Play, playButton,
        output p1Latch, p2Latch, result, roundValid, p1Score, p2Score,
               roundCount, matchOver, badPlay
    );
endinterface

// File: rtl/rps_button_cond.sv
// Button conditioner: 2-flop sync, optional debounce (RPS_DEBOUNCE_EN), registered falling-edge press.
// Level valid 2 edges after the raw input (+DEBOUNCE_CYCLES with debounce); press one edge after level; no backpressure.
module rps_button_cond #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    logic sync1, sync2, level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef RPS_DEBOUNCE_EN
    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic           deb;
    logic [DCW-1:0] deb_cnt;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive sample that disagrees with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb     <= 1'b1;
            deb_cnt <= '0;
        end else if (sync2 == deb) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DCW'(DEBOUNCE_CYCLES - 1)) begin
            deb     <= sync2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DCW'(1);
        end
    end

    assign level = deb;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b1;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level_q & ~level;
        end
    end

endmodule

// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match controller; debounce compiled in with RPS_DEBOUNCE_EN.
// Plays latch 3 edges after the first low sample (2+DEBOUNCE_CYCLES+1 with debounce); no backpressure, presses outside WAIT_PRESS/MATCH_OVER are dropped.
module rps_match_ctrl
    import rps_pkg::*;
#(
    parameter int WIN_TARGET      = 3,
    parameter int REVEAL_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    rps_match_ctrl_if.slave  bus
);

    localparam int RCW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;

    logic level, press;

    rps_button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_button_cond (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.playButton),
        .level (level),
        .press (press)
    );

    state_t         state, state_n;
    logic [RCW-1:0] rev_cnt;
    logic [1:0]     p1_lat, p2_lat;
    result_t        result_q;
    logic [3:0]     p1_score, p2_score, p1_next, p2_next;
    logic [7:0]     round_cnt;
    logic           round_valid, match_over, bad_play;
    logic           do_latch, do_reject, do_score, do_clear;

    always_comb begin
        state_n   = state;
        do_latch  = 1'b0;
        do_reject = 1'b0;
        do_score  = 1'b0;
        do_clear  = 1'b0;
        p1_next   = p1_score + {3'b000, (result_q == RES_P1)};
        p2_next   = p2_score + {3'b000, (result_q == RES_P2)};
        case (state)
            WAIT_RELEASE: if (level) state_n = WAIT_PRESS;
            WAIT_PRESS: begin
                if (press) begin
                    if (bus.p1Play == NONE || bus.p2Play == NONE) begin
                        do_reject = 1'b1;
                        state_n   = WAIT_RELEASE;
                    end else begin
                        do_latch  = 1'b1;
                        state_n   = REVEAL;
                    end
                end
            end
            REVEAL: if (rev_cnt == RCW'(REVEAL_CYCLES - 1)) state_n = SCORE;
            SCORE: begin
                do_score = 1'b1;
                if (p1_next == 4'(WIN_TARGET) || p2_next == 4'(WIN_TARGET))
                    state_n = MATCH_OVER;
                else
                    state_n = WAIT_RELEASE;
            end
            MATCH_OVER: begin
                if (press) begin
                    do_clear = 1'b1;
                    state_n  = WAIT_RELEASE;
                end
            end
            default: state_n = WAIT_RELEASE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_RELEASE;
            rev_cnt     <= '0;
            p1_lat      <= 2'b00;
            p2_lat      <= 2'b00;
            result_q    <= RES_NONE;
            p1_score    <= 4'd0;
            p2_score    <= 4'd0;
            round_cnt   <= 8'd0;
            round_valid <= 1'b0;
            match_over  <= 1'b0;
            bad_play    <= 1'b0;
        end else begin
            state       <= state_n;
            rev_cnt     <= (state == REVEAL) ? rev_cnt + RCW'(1) : '0;
            round_valid <= (state_n == REVEAL);
            match_over  <= (state_n == MATCH_OVER);
            bad_play    <= do_reject;
            if (do_latch) begin
                p1_lat   <= bus.p1Play;
                p2_lat   <= bus.p2Play;
                result_q <= rps_winner(bus.p1Play, bus.p2Play);
            end
            if (do_score) begin
                p1_score  <= p1_next;
                p2_score  <= p2_next;
                round_cnt <= round_cnt + 8'd1;
            end
            if (do_clear) begin
                p1_lat    <= 2'b00;
                p2_lat    <= 2'b00;
                result_q  <= RES_NONE;
                p1_score  <= 4'd0;
                p2_score  <= 4'd0;
                round_cnt <= 8'd0;
            end
        end
    end

    assign bus.p1Latch    = p1_lat;
    assign bus.p2Latch    = p2_lat;
    assign bus.result     = result_q;
    assign bus.roundValid = round_valid;
    assign bus.p1Score    = p1_score;
    assign bus.p2Score    = p2_score;
    assign bus.roundCount = round_cnt;
    assign bus.matchOver  = match_over;
    assign bus.badPlay    = bad_play;

endmodule
